// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier and its neighbours.
package mult_pkg;

    // Default operand width; the product is twice this.
    localparam int DEF_WIDTH = 4;

    // Controller state encoding, shared with the shifter-stage neighbour.
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN
    } mult_state_e;

endpackage : mult_pkg

// File: rtl/shift_add_step.sv
// One combinational shift-and-add iteration. It conditionally adds the
// multiplicand into the accumulator, then shifts both operands for the next bit.
module shift_add_step #(
    parameter int WIDTH = 4
) (
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mult,
    input  logic [2*WIDTH-1:0] acc,
    output logic [2*WIDTH-1:0] next_mcand,
    output logic [WIDTH-1:0]   next_mult,
    output logic [2*WIDTH-1:0] next_acc
);

    // The add cannot overflow: the partial sum never exceeds (2^WIDTH-1)^2.
    always_comb begin
        next_acc   = acc + (mult[0] ? mcand : '0);
        next_mcand = mcand << 1;
        next_mult  = mult >> 1;
    end

endmodule : shift_add_step

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier. It latches the operands on start,
// runs WIDTH add/shift steps, and then registers the product with a one-cycle done.
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int             PW   = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mult_state_e        state_q, state_d;
    logic [PW-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]   mult_q,  mult_d;
    logic [PW-1:0]      acc_q,   acc_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [PW-1:0]      prod_q,  prod_d;
    logic               done_q,  done_d;

    logic [PW-1:0]      step_mcand;
    logic [WIDTH-1:0]   step_mult;
    logic [PW-1:0]      step_acc;

    shift_add_step #(.WIDTH(WIDTH)) u_step (
        .mcand      (mcand_q),
        .mult       (mult_q),
        .acc        (acc_q),
        .next_mcand (step_mcand),
        .next_mult  (step_mult),
        .next_acc   (step_acc)
    );

    // State and datapath registers, which are cleared immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            mult_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mult_q  <= mult_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic. While busy, start is ignored. The final step writes the
    // accumulated sum directly into product, so no extra cycle is needed.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mult_d  = mult_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = {{WIDTH{1'b0}}, a};
                    mult_d  = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                mcand_d = step_mcand;
                mult_d  = step_mult;
                acc_d   = step_acc;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    prod_d  = step_acc;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy    = (state_q == S_RUN);
    assign done    = done_q;
    assign product = prod_q;

endmodule : shift_add_mult_ctrl
